board_win_checker: RTL and testbench



---
 rtl/board_win_checker.sv | 111 +++++++++++
 tb/tb_board_win_checker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/board_win_checker.sv
// board_win_checker: loads a ROWSxCOLS Connect-4 board from RAM (ram_address/ram_q), scans it for WIN_LEN runs, reports busy/done/winner/draw/board_out
module board_win_checker #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int WIN_LEN = 4,
  parameter int ADDR_W = 6
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDR_W-1:0]        ram_address,
  input  logic [1:0]               ram_q,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               winner,
  output logic                     draw,
  output logic [2*ROWS*COLS-1:0]   board_out
);
  localparam int N = ROWS * COLS;
  localparam int IW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
  state_t st_q, st_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] winner_q, winner_d;
  logic draw_q, draw_d;
  logic [2*N-1:0] board_q, board_d;
  logic [(1<<IW)-1:0] hit1_v, hit2_v;
  logic [N-1:0] full_v;
  assign hit1_v[(1<<IW)-1:N] = '0;
  assign hit2_v[(1<<IW)-1:N] = '0;
  for (genvar k = 0; k < N; k++) begin : g_cell
    localparam int R = k / COLS;
    localparam int C = k % COLS;
    logic [1:0] own;
    logic [3:0] dir;
    assign own = board_q[2*k +: 2];
    assign board_d[2*k +: 2] = (st_q == LOAD && cnt_q == IW'(k + 1)) ? ram_q : own;
    assign full_v[k] = ^own;
    assign hit1_v[k] = own == 2'b01 && |dir;
    assign hit2_v[k] = own == 2'b10 && |dir;
    for (genvar d = 0; d < 4; d++) begin : g_dir
      localparam int DR = d == 0 ? 0 : 1;
      localparam int DC = d == 1 ? 0 : (d == 3 ? -1 : 1);
      localparam int ER = R + DR * (WIN_LEN - 1);
      localparam int EC = C + DC * (WIN_LEN - 1);
      if (ER < ROWS && EC >= 0 && EC < COLS) begin : g_fit
        logic [WIN_LEN-1:0] m;
        for (genvar s = 0; s < WIN_LEN; s++) begin : g_step
          localparam int KS = (R + DR * s) * COLS + C + DC * s;
          assign m[s] = board_q[2*KS +: 2] == own;
        end
        assign dir[d] = &m;
      end else begin : g_nofit
        assign dir[d] = 1'b0;
      end
    end
  end
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    winner_d = winner_q;
    draw_d = draw_q;
    if (st_q == IDLE && start) begin
      st_d = LOAD;
      cnt_d = '0;
      addr_d = '0;
      winner_d = 2'b00;
      draw_d = 1'b0;
    end else if (st_q == LOAD) begin
      addr_d = addr_q == ADDR_W'(N - 1) ? addr_q : addr_q + 1'b1;
      cnt_d = cnt_q == IW'(N) ? '0 : cnt_q + 1'b1;
      st_d = cnt_q == IW'(N) ? CHECK : LOAD;
    end else if (st_q == CHECK) begin
      cnt_d = cnt_q + 1'b1;
      if (hit1_v[cnt_q] || hit2_v[cnt_q]) begin
        winner_d = {hit2_v[cnt_q], hit1_v[cnt_q]};
        st_d = DONE;
      end else if (cnt_q == IW'(N - 1)) begin
        draw_d = &full_v;
        st_d = DONE;
      end
    end else if (st_q == DONE) begin
      st_d = IDLE;
    end
  end
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      winner_q <= 2'b00;
      draw_q <= 1'b0;
      board_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      winner_q <= winner_d;
      draw_q <= draw_d;
      board_q <= board_d;
    end
  end
  assign ram_address = addr_q;
  assign busy = st_q == LOAD || st_q == CHECK;
  assign done = st_q == DONE;
  assign winner = winner_q;
  assign draw = draw_q;
  assign board_out = board_q;
endmodule

// File: tb/tb_board_win_checker.sv
// tb_board_win_checker: directed table plus random boards checked against a reference Connect-4 model
module tb_board_win_checker;
  localparam int ROWS = 6, COLS = 7, WL = 4, AW = 6, N = ROWS * COLS;
  logic Clk = 0, reset = 1, start = 0;
  logic [AW-1:0] ram_address;
  logic [1:0] ram_q = 0;
  logic busy, done, draw;
  logic [1:0] winner;
  logic [2*N-1:0] board_out;
  logic [1:0] mem [64];
  int n_cmp = 0, n_bad = 0;

  board_win_checker #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WL), .ADDR_W(AW)) dut (
    .Clk(Clk), .reset(reset), .start(start), .ram_address(ram_address), .ram_q(ram_q),
    .busy(busy), .done(done), .winner(winner), .draw(draw), .board_out(board_out)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) ram_q <= mem[ram_address];

  typedef struct {int pat; logic [1:0] w; bit d; int de;} vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setup(input int pat);
    for (int k = 0; k < 64; k++) mem[k] = 2'b00;
    case (pat)
      1: for (int k = 0; k < 4; k++) mem[k] = 2'b01;
      2: begin mem[20] = 2'b10; mem[27] = 2'b10; mem[34] = 2'b10; mem[41] = 2'b10; end
      3: begin mem[3] = 2'b01; mem[9] = 2'b01; mem[15] = 2'b01; mem[21] = 2'b01; end
      4: begin mem[0] = 2'b10; mem[8] = 2'b10; mem[16] = 2'b10; mem[24] = 2'b10; end
      5, 6: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) mem[r*COLS+c] = 2'(1 + ((r / 2 + c) % 2));
        if (pat == 6) mem[41] = 2'b11;
      end
      default: ;
    endcase
  endtask

  function automatic void model(output logic [1:0] w, output bit d, output int de);
    int dr_t[4];
    int dc_t[4];
    dr_t = '{0, 1, 1, 1};
    dc_t = '{1, 0, 1, -1};
    w = 2'b00;
    d = 1'b1;
    de = 2 * N + 1;
    for (int k = 0; k < N; k++) begin
      if (mem[k] == 2'b01 || mem[k] == 2'b10) begin
        for (int j = 0; j < 4; j++) begin
          bit ok = 1;
          for (int s = 0; s < WL; s++) begin
            int rr = k / COLS + dr_t[j] * s;
            int cc = k % COLS + dc_t[j] * s;
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 0;
            else if (mem[rr*COLS+cc] != mem[k]) ok = 0;
          end
          if (ok) begin
            w = mem[k];
            d = 1'b0;
            de = N + 2 + k;
            return;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) if (mem[k] == 2'b00 || mem[k] == 2'b11) d = 1'b0;
  endfunction

  task automatic run(input string nm, input logic [1:0] ew, input bit ed, input int edone, input int glitch);
    int seen = -1;
    bit busy_ok = 1;
    logic [2*N-1:0] exp_board;
    for (int k = 0; k < N; k++) exp_board[2*k +: 2] = mem[k];
    @(posedge Clk); #1 start = 1;
    @(posedge Clk); #1 start = 0;
    for (int e = 1; e <= 2 * N + 20; e++) begin
      start = (e == glitch);
      @(posedge Clk); #1;
      if (done) seen = e;
      if (e < edone && !busy) busy_ok = 0;
      if (seen >= 0) break;
    end
    start = 0;
    chk({nm, " done_edge"}, seen, edone);
    chk({nm, " busy"}, busy_ok, 1);
    chk({nm, " winner"}, winner, ew);
    chk({nm, " draw"}, draw, ed);
    chk({nm, " board"}, board_out, exp_board);
    @(posedge Clk); #1;
    chk({nm, " done_pulse"}, {done, busy}, 2'b00);
    repeat (3) @(posedge Clk);
    #1 chk({nm, " hold"}, {winner, draw}, {ew, ed});
  endtask

  initial begin
    logic [1:0] ew;
    bit ed;
    int de;
    int seen;
    tbl[0] = '{0, 2'b00, 1'b0, 85};
    tbl[1] = '{1, 2'b01, 1'b0, 44};
    tbl[2] = '{2, 2'b10, 1'b0, 64};
    tbl[3] = '{3, 2'b01, 1'b0, 47};
    tbl[4] = '{4, 2'b10, 1'b0, 44};
    tbl[5] = '{5, 2'b00, 1'b1, 85};
    tbl[6] = '{6, 2'b00, 1'b0, 85};
    setup(0);
    repeat (2) @(posedge Clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst winner", winner, 0);
    chk("rst draw", draw, 0);
    chk("rst addr", ram_address, 0);
    chk("rst board", board_out, 0);
    reset = 0;
    for (int i = 0; i < 7; i++) begin
      setup(tbl[i].pat);
      run($sformatf("vec%0d", i), tbl[i].w, tbl[i].d, tbl[i].de, -1);
    end
    for (int t = 0; t < 24; t++) begin
      if (t % 3 == 0) begin
        setup(5);
        for (int f = 0; f < 1 + t % 2; f++) mem[$urandom_range(0, N - 1)] = 2'($urandom_range(1, 2));
      end else begin
        int fill = $urandom_range(20, 95);
        for (int k = 0; k < 64; k++) mem[k] = 2'b00;
        for (int k = 0; k < N; k++)
          mem[k] = ($urandom_range(0, 99) < fill) ? 2'($urandom_range(1, 2))
                 : ($urandom_range(0, 9) == 0 ? 2'b11 : 2'b00);
      end
      model(ew, ed, de);
      run($sformatf("rnd%0d", t), ew, ed, de, -1);
    end
    setup(1);
    @(posedge Clk); #1 start = 1;
    @(posedge Clk); #1 start = 0;
    repeat (20) @(posedge Clk);
    #1 reset = 1;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst addr", ram_address, 0);
    chk("mid rst board", board_out, 0);
    chk("mid rst results", {winner, draw}, 3'b000);
    @(posedge Clk); #1 reset = 0;
    seen = 0;
    repeat (120) begin
      @(posedge Clk); #1;
      if (done || busy) seen = 1;
    end
    chk("no done after rst", seen, 0);
    setup(0);
    run("glitch", 2'b00, 1'b0, 85, 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
